// File: rtl/sram_like_slave.sv
// Responder for the sram-like req/addr_ok/data_ok interface, backed by a word array.
// Responses come back in order after a programmable latency; address-phase stalls come from an optional LFSR.
module sram_like_slave #(
    parameter int          AW       = 12,
    parameter int          LAT      = 1,
    parameter int          MAX_OUT  = 4,
    parameter bit          STALL_EN = 1'b0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_req,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata
);
    localparam int            PW   = $clog2(MAX_OUT);
    localparam int            CW   = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_OUT);
    localparam logic [3:0]    LAT4 = 4'(LAT);

    logic [31:0]   mem_q        [2**AW];
    logic [31:0]   fifo_rdata_q [MAX_OUT];
    logic [31:0]   fifo_rdata_d [MAX_OUT];
    logic [3:0]    fifo_stamp_q [MAX_OUT];
    logic [3:0]    fifo_stamp_d [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    cyc_q, cyc_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic [AW-1:0] word_idx_s;
    logic [3:0]    head_age_s;
    logic          stall_s;
    logic          accept_s;
    logic          release_s;
    logic          is_write_s;
    logic          unused_addr_s;

    assign word_idx_s    = sram_addr[AW+1:2];
    assign unused_addr_s = ^{sram_addr[31:AW+2], sram_addr[1:0]};

    // Handshake, head release decision and response outputs
    always_comb begin
        stall_s      = STALL_EN && (lfsr_q[1:0] == 2'b00);
        sram_addr_ok = !reset && (count_q != FULL) && !stall_s;
        accept_s     = sram_req && sram_addr_ok;
        is_write_s   = (sram_wen != 4'h0);
        // Age is modular; an entry never waits 16 cycles, so this cannot alias
        head_age_s   = cyc_q - fifo_stamp_q[rd_ptr_q];
        release_s    = !reset && (count_q != {CW{1'b0}}) && (head_age_s >= LAT4);
        sram_data_ok = release_s;
        if (release_s) begin
            sram_rdata = fifo_rdata_q[rd_ptr_q];
        end else begin
            sram_rdata = 32'h0;
        end
    end

    // Response FIFO payload: reads capture the word before this edge's update
    always_comb begin
        fifo_rdata_d = fifo_rdata_q;
        fifo_stamp_d = fifo_stamp_q;
        if (accept_s) begin
            fifo_rdata_d[wr_ptr_q] = is_write_s ? 32'h0 : mem_q[word_idx_s];
            fifo_stamp_d[wr_ptr_q] = cyc_q;
        end else begin
            fifo_rdata_d[wr_ptr_q] = fifo_rdata_q[wr_ptr_q];
            fifo_stamp_d[wr_ptr_q] = fifo_stamp_q[wr_ptr_q];
        end
    end

    // Pointers, occupancy, cycle counter and stall LFSR next state
    always_comb begin
        wr_ptr_d = accept_s  ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = release_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
        case ({accept_s, release_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        cyc_d  = cyc_q + 4'd1;
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Control state registers; reset drops every outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            cyc_q    <= 4'd0;
            lfsr_q   <= SEED;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // FIFO payload registers; validity is tracked by count, so no reset
    always_ff @(posedge clk) begin
        fifo_rdata_q <= fifo_rdata_d;
        fifo_stamp_q <= fifo_stamp_d;
    end

    // Byte-lane writes into the word array; contents survive reset
    always_ff @(posedge clk) begin
        if (accept_s && is_write_s) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wen[b]) begin
                    mem_q[word_idx_s][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: four instances (LAT 1/8/3/5, the last with stalls) checked every
// cycle against a queue-based reference model, plus directed latency, full, stall and reset scenarios.
module tb_sram_like_slave;
    localparam int NDUT  = 4;
    localparam int AW    = 6;
    localparam int WORDS = 2**AW;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        req   [NDUT];
    logic [3:0]  wen   [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic        aok   [NDUT];
    logic        dok   [NDUT];
    logic [31:0] rdata [NDUT];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    logic [31:0] pre_word [NDUT][WORDS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    for (genvar G = 0; G < NDUT; G++) begin : g_dut
        localparam int LAT_G   = (G == 0) ? 1 : (G == 1) ? 8 : (G == 2) ? 3 : 5;
        localparam bit STALL_G = (G == 3);
        localparam int MOUT    = 4;

        sram_like_slave #(
            .AW(AW), .LAT(LAT_G), .MAX_OUT(MOUT), .STALL_EN(STALL_G), .SEED(16'hACE1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .sram_req(req[G]), .sram_wen(wen[G]), .sram_addr(addr[G]), .sram_wdata(wdata[G]),
            .sram_addr_ok(aok[G]), .sram_data_ok(dok[G]), .sram_rdata(rdata[G])
        );

        // Reference model: response queue with absolute due cycles, word array, LFSR
        rsp_t        mq[$];
        logic [31:0] mdl_mem [WORDS];
        logic [15:0] mlfsr;
        int          now_c;
        bit          started = 1'b0;
        int          outstanding = 0;
        int          n_acc = 0;

        function automatic bit m_stall();
            return STALL_G && (mlfsr[1:0] == 2'b00);
        endfunction

        initial forever begin
            bit e_aok, e_dok;
            logic [31:0] e_rd;
            @(negedge clk);
            if (started) begin
                e_aok = !reset && (mq.size() != MOUT) && !m_stall();
                e_dok = 1'b0;
                e_rd  = 32'h0;
                if (!reset && mq.size() > 0) begin
                    if (mq[0].due <= now_c) begin
                        e_dok = 1'b1;
                        e_rd  = mq[0].data;
                    end
                end
                check($sformatf("m%0d_aok", G), {31'h0, aok[G]}, {31'h0, e_aok});
                check($sformatf("m%0d_dok", G), {31'h0, dok[G]}, {31'h0, e_dok});
                check($sformatf("m%0d_rdata", G), rdata[G], e_rd);
            end
        end

        initial forever begin
            bit rel, acc;
            int idx, due;
            logic [31:0] md;
            @(posedge clk);
            if (reset) begin
                mq.delete();
                now_c   = 0;
                mlfsr   = 16'hACE1;
                started = 1'b1;
            end else if (started) begin
                rel = (mq.size() > 0) && (mq[0].due <= now_c);
                acc = req[G] && (mq.size() != MOUT) && !m_stall();
                if (acc) begin
                    idx = int'(addr[G][AW+1:2]);
                    if (wen[G] == 4'h0) begin
                        md = mdl_mem[idx];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (wen[G][b]) mdl_mem[idx][8*b +: 8] = wdata[G][8*b +: 8];
                        md = 32'h0;
                    end
                    due = now_c + LAT_G;
                    if (mq.size() > 0 && mq[$].due + 1 > due) due = mq[$].due + 1;
                    mq.push_back('{md, due});
                    n_acc++;
                end
                if (rel) void'(mq.pop_front());
                mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
                now_c++;
            end
            outstanding = mq.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < NDUT; g++) begin
            req[g] = 1'b0; wen[g] = 4'h0; addr[g] = 32'h0; wdata[g] = 32'h0;
        end
    endtask

    task automatic do_reset();
        tick();
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int pidx [NDUT];
        int done_cnt, issued, k, acc3, dok3, macc0;
        bit reached;
        bit aok_log [32];
        int dok_rel[$];
        logic [31:0] dok_dat[$];
        int exp_rel1 [6];
        int exp_rel2 [4];
        exp_rel1 = '{8, 9, 10, 11, 17, 18};
        exp_rel2 = '{3, 4, 13, 23};

        idle_all();
        reset = 1'b1;
        tick();
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) check("reset_aok", {31'h0, aok[g]}, 32'h0);
        tick();
        reset = 1'b0;

        // Preload every word of every instance through full-word writes
        for (int g = 0; g < NDUT; g++) pidx[g] = 0;
        done_cnt = 0;
        for (int c = 0; c < 600 && done_cnt < NDUT * WORDS; c++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                req[g]   = (pidx[g] < WORDS);
                wen[g]   = 4'hF;
                addr[g]  = (32'(pidx[g]) << 2) | ($urandom & 32'hFFFF_FF03);
                wdata[g] = (pidx[g] == 5) ? 32'h1234_5678 :
                           (pidx[g] == 8) ? 32'hFFFF_FFFF : $urandom;
            end
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (req[g] && aok[g]) begin
                    pre_word[g][pidx[g]] = wdata[g];
                    pidx[g]++;
                    done_cnt++;
                end
            end
        end
        check("preload_done", 32'(done_cnt), 32'(NDUT * WORDS));
        tick();
        idle_all();
        repeat (20) tick();
        do_reset();

        // First cycle after reset
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("post_rst_aok", {31'h0, aok[g]}, 32'h1);
            check("post_rst_dok", {31'h0, dok[g]}, 32'h0);
            check("post_rst_rdata", rdata[g], 32'h0);
        end

        // Single read on the LAT=1 instance in cycle 3
        while (cyc < 3) tick();
        req[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'h0000_0014;
        @(negedge clk);
        check("rd_aok_c3", {31'h0, aok[0]}, 32'h1);
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        check("rd_dok_c4", {31'h0, dok[0]}, 32'h1);
        check("rd_data_c4", rdata[0], 32'h1234_5678);
        tick();
        @(negedge clk);
        check("rd_dok_c5", {31'h0, dok[0]}, 32'h0);

        // Byte write to word 8 followed by a read the next cycle
        tick();
        req[0] = 1'b1; wen[0] = 4'b0011; addr[0] = 32'h20; wdata[0] = 32'hAAAA_BBBB;
        @(negedge clk);
        check("bw_aok", {31'h0, aok[0]}, 32'h1);
        tick();
        wen[0] = 4'h0; wdata[0] = 32'h0;
        @(negedge clk);
        check("bw_wr_dok", {31'h0, dok[0]}, 32'h1);
        check("bw_wr_rdata", rdata[0], 32'h0);
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        check("bw_rd_dok", {31'h0, dok[0]}, 32'h1);
        check("bw_rd_rdata", rdata[0], 32'hFFFF_BBBB);

        // Full FIFO and ordering on the LAT=8 instance: six reads, req held high
        issued = 0;
        for (int r = 0; r < 25; r++) begin
            tick();
            req[1] = (issued < 6); wen[1] = 4'h0; addr[1] = 32'(10 + issued) << 2;
            @(negedge clk);
            aok_log[r] = aok[1];
            if (req[1] && aok[1]) issued++;
            if (dok[1]) begin
                dok_rel.push_back(r);
                dok_dat.push_back(rdata[1]);
            end
        end
        check("full_issued", 32'(issued), 32'd6);
        for (int r = 0; r < 10; r++)
            check($sformatf("full_aok_r%0d", r), {31'h0, aok_log[r]}, {31'h0, (r < 4 || r == 9)});
        check("full_ndok", 32'(dok_rel.size()), 32'd6);
        for (int i = 0; i < 6 && i < dok_rel.size(); i++) begin
            check($sformatf("full_rel%0d", i), 32'(dok_rel[i]), 32'(exp_rel1[i]));
            check($sformatf("full_dat%0d", i), dok_dat[i], pre_word[1][10 + i]);
        end

        // Latency spacing on the LAT=3 instance: accepts at rel 0, 1, 10, 20
        dok_rel.delete();
        for (int r = 0; r < 30; r++) begin
            tick();
            req[1] = 1'b0;
            req[2] = (r == 0 || r == 1 || r == 10 || r == 20);
            wen[2] = 4'h0;
            addr[2] = $urandom;
            @(negedge clk);
            if (req[2]) check($sformatf("sp_aok_r%0d", r), {31'h0, aok[2]}, 32'h1);
            if (dok[2]) dok_rel.push_back(r);
        end
        check("sp_ndok", 32'(dok_rel.size()), 32'd4);
        for (int i = 0; i < 4 && i < dok_rel.size(); i++)
            check($sformatf("sp_rel%0d", i), 32'(dok_rel[i]), 32'(exp_rel2[i]));

        // Randomized traffic on all instances; the stalling one has req held high
        acc3  = 0;
        dok3  = 0;
        macc0 = g_dut[3].n_acc;
        for (int c = 0; c < 1000; c++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                req[g]   = (g == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                wen[g]   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                addr[g]  = $urandom;
                wdata[g] = $urandom;
            end
            @(negedge clk);
            if (req[3] && aok[3]) acc3++;
            if (dok[3]) dok3++;
        end
        tick();
        idle_all();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dok[3]) dok3++;
            tick();
        end
        check("stall_acc_vs_dok", 32'(acc3), 32'(dok3));
        check("stall_acc_vs_model", 32'(acc3), 32'(g_dut[3].n_acc - macc0));

        // Reset with three requests outstanding on the LAT=5 stalling instance
        k = 0;
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            tick();
            reached = (g_dut[3].outstanding == 3);
            if (!reached) begin
                req[3]   = 1'b1;
                wen[3]   = (k == 0) ? 4'hF : 4'h0;
                addr[3]  = 32'(40 + k) << 2;
                wdata[3] = 32'hC0DE_0003;
                @(negedge clk);
                if (aok[3]) k++;
            end
        end
        check("mid_reached3", {31'h0, reached}, 32'h1);
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req[3] = 1'b1; wen[3] = 4'h0; addr[3] = 32'(40) << 2;
        @(negedge clk);
        check("mid_aok_c0", {31'h0, aok[3]}, 32'h1);
        check("mid_dok_c0", {31'h0, dok[3]}, 32'h0);
        for (int c = 1; c < 5; c++) begin
            tick();
            req[3] = 1'b0;
            @(negedge clk);
            check($sformatf("mid_dok_c%0d", c), {31'h0, dok[3]}, 32'h0);
        end
        tick();
        @(negedge clk);
        check("mid_dok_c5", {31'h0, dok[3]}, 32'h1);
        check("mid_rdata_c5", rdata[3], 32'hC0DE_0003);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
